fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the MIPS pipeline. It owns the program counter, drives the instruction ROM address, and captures the returned word into the IF/ID pipeline register. It also performs next-PC selection for sequential, branch, jump, jr, interrupt and exception flow, and handles stall and flush requests from the downstream hazard logic.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC value loaded on reset.
- `IRQ_VEC`, default 32'h8000_0004: interrupt entry address.
- `EXC_VEC`, default 32'h8000_0008: exception entry address.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  31  ROM byte address, equal to `pc[30:0]`. Combinational from the PC register.
- `imem_data`  in  32  ROM read word, combinational, valid in the same cycle.
- `stall`  in  1  holds the PC and IF/ID register.
- `flush`  in  1  loads a bubble into IF/ID.
- `pc_sel`  in  2  next-PC source: 0 = SEQ, 1 = BRANCH, 2 = JUMP, 3 = JR.
- `branch_target`  in  32  branch destination, computed in ID.
- `jump_index`  in  26  J/JAL index field.
- `jr_target`  in  32  register value for jr/jalr.
- `exc`  in  1  exception request; redirects to `EXC_VEC`.
- `irq`  in  1  level-sensitive external interrupt.
- `pc`  out  32  current PC.
- `if_id_instr`  out  32  latched instruction.
- `if_id_pc4`  out  32  latched PC+4.
- `if_id_valid`  out  1  latched slot holds a real instruction.
- `irq_taken`  out  1  one-cycle pulse when an interrupt redirect occurs.
- `epc`  out  32  return address captured on an interrupt or exception.

## Operation
- Candidate next-PC values:
  - SEQ = `pc+4`. Arithmetic is 32-bit and wraps modulo 2^32.
  - JUMP = `{pc[31:28], jump_index, 2'b00}`.
  - BRANCH and JR take their input verbatim. The JR target keeps its bit 31 unless it would enter kernel space from user mode: if `pc[31]==0`, bit 31 of the new PC is forced to 0.
- Next-PC priority, highest first:
  1. `exc`: PC ← `EXC_VEC`; `epc` ← `pc`. Overrides `stall`.
  2. `stall`: PC and IF/ID hold; `pc_sel` and `irq` are ignored.
  3. `irq` with `pc[31]==0`: PC ← `IRQ_VEC`; `epc` ← `pc`; `irq_taken` is pulsed. `irq` is ignored while in kernel mode (`pc[31]==1`).
  4. `pc_sel` source.
- IF/ID update when not stalled:
  - If `flush`, `exc` or an `irq` redirect is active: `if_id_instr` ← 0 (nop), `if_id_valid` ← 0, `if_id_pc4` ← 0.
  - Otherwise: `if_id_instr` ← `imem_data`, `if_id_pc4` ← `pc+4`, `if_id_valid` ← 1.
- `flush` with `stall`: stall wins for PC, but IF/ID still takes the bubble. Flush must never be lost.
- An `imem_addr` outside ROM returns 0 from the ROM. That word is latched as a nop with `if_id_valid` = 1; no fault is raised.

## Timing
- Reset, asynchronous on `rst_n` low:
  - `pc` = `RESET_PC`
  - `if_id_instr` = 0, `if_id_pc4` = 0, `if_id_valid` = 0
  - `epc` = 0, `irq_taken` = 0
- Fetch latency: the instruction at address A appears on `if_id_instr` on the first edge after `pc == A`, i.e. 1 cycle.
- Redirects take effect on the same edge they are sampled. The word fetched in that cycle is discarded only if `flush` is asserted; branch-delay behaviour is therefore set by the hazard unit.
- `irq_taken` is high for exactly the cycle following the redirect edge.
- If reset deasserts mid-stall, the first fetch is at `RESET_PC` on the first edge after release.

## Configuration
- `FETCH_IRQ_EN` defined: interrupt path, `irq_taken` logic and `IRQ_VEC` redirect are present.
- `FETCH_IRQ_EN` undefined:
  - `irq` is ignored and `irq_taken` is tied to 0.
  - `epc` updates only on `exc`.
  - All other behaviour is identical.

## Structure
- `cpu_pkg` holds:
  - `pc_sel_t` encoding: SEQ, BRANCH, JUMP, JR.
  - Vector constants for `RESET_PC`, `IRQ_VEC`, `EXC_VEC`.
  - `NOP_INSTR` = 32'h0.
- Sub-module `next_pc_mux`: purely combinational priority and target computation. The stage itself holds only registers and control.

## Test plan
- Reset, then 3 free-running cycles → `pc` 8000_0000 → 8000_0004 → 8000_0008; `if_id_instr` follows ROM words 0, 1, 2; `imem_addr` = 000_0000 → 000_0004 → 000_0008.
- `pc` = 8000_0008, `pc_sel`=JUMP, `jump_index`=4 → next `pc` = 8000_0010.
- `pc_sel`=BRANCH with `branch_target`=8000_000C, `flush`=1 → `pc` = 8000_000C; `if_id_valid` = 0 for one cycle.
- `stall` held for 2 cycles with `pc_sel`=JR → `pc` and `if_id_*` unchanged; `exc` during the stall → `pc` = 8000_0008 and `epc` = held PC.
- `pc` = 0000_0040, `irq`=1 → `pc` = 8000_0004, `epc` = 0000_0040, `irq_taken` pulses 1 cycle. Holding `irq` afterwards causes no second redirect (kernel mode). With `FETCH_IRQ_EN` undefined, the same stimulus gives `pc` = 0000_0044.
- `rst_n` dropped mid-fetch at `pc` = 8000_0020 → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: next-PC source encoding, vector addresses, nop encoding.
package cpu_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pc_sel_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    function automatic logic [31:0] jump_addr(input logic [31:0] pc, input logic [25:0] index);
        return {pc[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection: exception > stall > interrupt > pc_sel source.
module next_pc_mux
    import cpu_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        exc,
    input  logic        irq_req,
    input  pc_sel_t     pc_sel,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        load_pc,
    output logic        irq_redirect
);

    logic [31:0] seq_pc;
    logic [31:0] sel_pc;
    logic        user_mode;

    assign seq_pc    = pc + 32'd4;
    assign user_mode = ~pc[31];

    always_comb begin
        sel_pc = seq_pc;
        case (pc_sel)
            PC_SEQ:    sel_pc = seq_pc;
            PC_BRANCH: sel_pc = branch_target;
            PC_JUMP:   sel_pc = jump_addr(pc, jump_index);
            // jr from user mode must not escalate into kernel space
            PC_JR:     sel_pc = {jr_target[31] & ~user_mode, jr_target[30:0]};
            default:   sel_pc = seq_pc;
        endcase
    end

    always_comb begin
        next_pc      = pc;
        load_pc      = 1'b0;
        irq_redirect = 1'b0;
        if (exc) begin
            next_pc = EXC_VEC;
            load_pc = 1'b1;
        end else if (stall) begin
            next_pc = pc;
            load_pc = 1'b0;
        end else if (irq_req && user_mode) begin
            next_pc      = IRQ_VEC;
            load_pc      = 1'b1;
            irq_redirect = 1'b1;
        end else begin
            next_pc = sel_pc;
            load_pc = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, ROM address, IF/ID register, epc capture.
// Interrupt support is compiled in only when FETCH_IRQ_EN is defined.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [30:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    input  logic        exc,
    input  logic        irq,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        irq_taken,
    output logic [31:0] epc
);

    logic [31:0] next_pc;
    logic        load_pc;
    logic        irq_redirect;
    logic        irq_req;
    logic        bubble;
    logic        if_id_load;

`ifdef FETCH_IRQ_EN
    assign irq_req = irq;
`else
    assign irq_req = irq & 1'b0;
`endif

    next_pc_mux #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_next_pc_mux (
        .pc            (pc),
        .stall         (stall),
        .exc           (exc),
        .irq_req       (irq_req),
        .pc_sel        (pc_sel_t'(pc_sel)),
        .branch_target (branch_target),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .next_pc       (next_pc),
        .load_pc       (load_pc),
        .irq_redirect  (irq_redirect)
    );

    assign imem_addr = pc[30:0];

    // a flush during a stall still bubbles IF/ID so it is never lost
    assign bubble     = flush | exc | irq_redirect;
    assign if_id_load = ~stall | bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc  <= RESET_PC;
            epc <= 32'h0;
        end else begin
            if (load_pc) begin
                pc <= next_pc;
            end
            if (exc || irq_redirect) begin
                epc <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (if_id_load) begin
            if (bubble) begin
                if_id_instr <= NOP_INSTR;
                if_id_pc4   <= 32'h0;
                if_id_valid <= 1'b0;
            end else begin
                if_id_instr <= imem_data;
                if_id_pc4   <= pc + 32'd4;
                if_id_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_taken <= 1'b0;
        end else begin
            irq_taken <= irq_redirect;
        end
    end
`else
    assign irq_taken = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a spec-level model checked every cycle plus literal pins.
module tb_fetch_stage;

`ifdef FETCH_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [30:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall, flush, exc, irq;
    logic [1:0]  pc_sel;
    logic [31:0] branch_target, jr_target;
    logic [25:0] jump_index;
    logic [31:0] pc, if_id_instr, if_id_pc4, epc;
    logic        if_id_valid, irq_taken;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .stall         (stall),
        .flush         (flush),
        .pc_sel        (pc_sel),
        .branch_target (branch_target),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .exc           (exc),
        .irq           (irq),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .irq_taken     (irq_taken),
        .epc           (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: 64 words at byte addresses 0..255, word i = A000_00ii; anything else reads 0
    function automatic logic [31:0] rom_word(input logic [30:0] a);
        if (a < 31'd256) return 32'hA000_0000 | {26'd0, a[7:2]};
        return 32'h0;
    endfunction

    assign imem_data = rom_word(imem_addr);

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_instr, m_pc4, m_epc;
    logic        m_valid, m_irq_taken;

    function automatic logic [31:0] model_target(input logic [31:0] cur);
        case (pc_sel)
            2'd1:    return branch_target;
            2'd2:    return (cur & 32'hF000_0000) + {4'd0, jump_index, 2'b00};
            2'd3:    return cur[31] ? jr_target : (jr_target & 32'h7FFF_FFFF);
            default: return cur + 32'd4;
        endcase
    endfunction

    function automatic bit model_irq_go(input logic [31:0] cur);
        return IRQ_EN && irq && !exc && !stall && (cur < 32'h8000_0000);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h8000_0000;
            m_instr <= 0; m_pc4 <= 0; m_valid <= 0;
            m_epc <= 0; m_irq_taken <= 0;
        end else begin
            m_irq_taken <= model_irq_go(m_pc);
            if (exc) begin
                m_pc <= 32'h8000_0008;
                m_epc <= m_pc;
            end else if (!stall) begin
                if (model_irq_go(m_pc)) begin
                    m_pc <= 32'h8000_0004;
                    m_epc <= m_pc;
                end else begin
                    m_pc <= model_target(m_pc);
                end
            end
            if (exc || flush || model_irq_go(m_pc)) begin
                m_instr <= 0; m_pc4 <= 0; m_valid <= 0;
            end else if (!stall) begin
                m_instr <= rom_word(m_pc[30:0]);
                m_pc4 <= m_pc + 32'd4;
                m_valid <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            check("pc", pc, m_pc);
            check("imem_addr", {1'b0, imem_addr}, {1'b0, m_pc[30:0]});
            check("if_id_instr", if_id_instr, m_instr);
            check("if_id_pc4", if_id_pc4, m_pc4);
            check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            check("irq_taken", {31'd0, irq_taken}, {31'd0, m_irq_taken});
            check("epc", epc, m_epc);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_imem_addr", {1'b0, imem_addr}, 32'h0);
        check("rst_instr", if_id_instr, 32'h0);
        check("rst_pc4", if_id_pc4, 32'h0);
        check("rst_valid", {31'd0, if_id_valid}, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_irq_taken", {31'd0, irq_taken}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; stall = 0; flush = 0; exc = 0; irq = 0;
        pc_sel = 2'd0; branch_target = 0; jump_index = 0; jr_target = 0;
        #12;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        #1;
        check("free0_pc", pc, 32'h8000_0000);

        step();
        check("free1_pc", pc, 32'h8000_0004);
        check("free1_instr", if_id_instr, 32'hA000_0000);
        check("free1_addr", {1'b0, imem_addr}, 32'h0000_0004);
        step();
        check("free2_pc", pc, 32'h8000_0008);
        check("free2_instr", if_id_instr, 32'hA000_0001);

        pc_sel = 2'd2; jump_index = 26'd4;
        step();
        check("jump_pc", pc, 32'h8000_0010);
        check("jump_instr", if_id_instr, 32'hA000_0002);

        pc_sel = 2'd1; branch_target = 32'h8000_000C; flush = 1;
        step();
        check("branch_pc", pc, 32'h8000_000C);
        check("flush_valid", {31'd0, if_id_valid}, 32'h0);
        flush = 0; pc_sel = 2'd0;
        step();
        check("after_flush_valid", {31'd0, if_id_valid}, 32'h1);
        check("after_flush_instr", if_id_instr, 32'hA000_0003);

        stall = 1; pc_sel = 2'd3; jr_target = 32'h0000_0040;
        step();
        step();
        check("stall_pc", pc, 32'h8000_0010);
        check("stall_instr", if_id_instr, 32'hA000_0003);
        exc = 1;
        step();
        check("exc_pc", pc, 32'h8000_0008);
        check("exc_epc", epc, 32'h8000_0010);
        check("exc_valid", {31'd0, if_id_valid}, 32'h0);
        exc = 0; stall = 0;

        jr_target = 32'h0000_0040;
        step();
        check("jr_kernel_pc", pc, 32'h0000_0040);
        jr_target = 32'h8000_0050;
        step();
        check("jr_user_forced", pc, 32'h0000_0050);
        pc_sel = 2'd1; branch_target = 32'h0000_0040;
        step();
        pc_sel = 2'd0; irq = 1;
        step();
        if (IRQ_EN) begin
            check("irq_pc", pc, 32'h8000_0004);
            check("irq_epc", epc, 32'h0000_0040);
            check("irq_taken_hi", {31'd0, irq_taken}, 32'h1);
        end else begin
            check("noirq_pc", pc, 32'h0000_0044);
            check("noirq_taken", {31'd0, irq_taken}, 32'h0);
        end
        step();
        check("irq_held_pc", pc, IRQ_EN ? 32'h8000_0008 : 32'h0000_0048);
        check("irq_taken_lo", {31'd0, irq_taken}, 32'h0);
        irq = 0;

        pc_sel = 2'd1; branch_target = 32'hFFFF_FFFC;
        step();
        check("high_addr", {1'b0, imem_addr}, 32'h7FFF_FFFC);
        pc_sel = 2'd0;
        step();
        check("wrap_pc", pc, 32'h0000_0000);
        check("oor_instr", if_id_instr, 32'h0);
        check("oor_valid", {31'd0, if_id_valid}, 32'h1);
        check("wrap_pc4", if_id_pc4, 32'h0);

        pc_sel = 2'd1; branch_target = 32'h8000_0020;
        step();
        pc_sel = 2'd0;
        for (int i = 0; i < 8; i++) begin
            pc_sel = 2'(i % 3);
            jump_index = 26'(8 + i);
            branch_target = 32'h8000_0020 + 32'(i * 4);
            flush = (i == 5);
            stall = (i == 6);
            step();
        end
        pc_sel = 2'd1; branch_target = 32'h8000_0020; flush = 0; stall = 0;
        step();
        pc_sel = 2'd0;
        check("pre_rst_pc", pc, 32'h8000_0020);
        #2;
        rst_n = 1'b0;
        stall = 1;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        step();
        check("rst_stall_pc", pc, 32'h8000_0000);
        check("rst_stall_valid", {31'd0, if_id_valid}, 32'h0);
        stall = 0;
        step();
        check("first_fetch_pc", pc, 32'h8000_0004);
        check("first_fetch_instr", if_id_instr, 32'hA000_0000);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
